// File: rtl/simon_pkg.sv
// Shared SIMON key-schedule definitions: z-sequences, FSM states and the
// legal parameter-tuple check used at elaboration.
package simon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int Z_LEN = 62;

    // Literals below are written element-0-first; flip so that bit j = element j.
    function automatic logic [61:0] z_rev(input logic [61:0] s);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) begin
            r[i] = s[61-i];
        end
        return r;
    endfunction

    localparam logic [4:0][61:0] Z_SEQ = {
        z_rev(62'b11010001111001101011011000100000010111000011001010010011101111),
        z_rev(62'b11011011101011000110010111100000010010001010011100110100001111),
        z_rev(62'b10101111011100000011010010011000101000010001111110010110110011),
        z_rev(62'b10001110111110010011000010110101000111011111001001100001011010),
        z_rev(62'b11111010001001010110000111001101111101000100101011000011100110)
    };

    function automatic bit simon_cfg_legal(input int n, input int m, input int t, input int zsel);
        return (n == 16 && m == 4 && t == 32 && zsel == 0) ||
               (n == 24 && m == 3 && t == 36 && zsel == 0) ||
               (n == 24 && m == 4 && t == 36 && zsel == 1) ||
               (n == 32 && m == 3 && t == 42 && zsel == 2) ||
               (n == 32 && m == 4 && t == 44 && zsel == 3) ||
               (n == 48 && m == 2 && t == 52 && zsel == 2) ||
               (n == 48 && m == 3 && t == 54 && zsel == 3) ||
               (n == 64 && m == 2 && t == 68 && zsel == 2) ||
               (n == 64 && m == 3 && t == 69 && zsel == 3) ||
               (n == 64 && m == 4 && t == 72 && zsel == 4);
    endfunction

endpackage

// File: rtl/simon_key_round.sv
// Combinational SIMON key-expansion step: next schedule word from the
// current M-word window and the active z-sequence bit.
module simon_key_round
    import simon_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic [M-1:0][N-1:0] window,
    input  logic                zbit,
    output logic [N-1:0]        new_word
);

    localparam logic [N-1:0] C_CONST = N'(3);

    logic [N-1:0] tmp_a;
    logic [N-1:0] tmp_b;

    always_comb begin
        tmp_a = {window[M-1][2:0], window[M-1][N-1:3]};
        if (M == 4) begin
            tmp_a = tmp_a ^ window[1];
        end
        tmp_b    = tmp_a ^ {tmp_a[0], tmp_a[N-1:1]};
        new_word = ~window[0] ^ tmp_b ^ {{(N-1){1'b0}}, zbit} ^ C_CONST;
    end

endmodule

// File: rtl/simon_key_scheduler.sv
// Streaming SIMON key schedule: loads an M-word master key, then emits the T
// round keys one per accepted beat from a registered shifting window.
module simon_key_scheduler
    import simon_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = 32,
    parameter int ZSEL = 0,
    parameter int CB   = $clog2(T)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [M*N-1:0] key_in,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic [N-1:0]   rk_out,
    output logic [CB-1:0]  rk_idx,
    output logic           rk_last
);

    if (!simon_cfg_legal(N, M, T, ZSEL)) begin : g_cfg_check
        $fatal(1, "simon_key_scheduler: illegal (N,M,T,ZSEL) combination");
    end

    localparam logic [CB-1:0] LAST_IDX = CB'(T - 1);
    localparam logic [61:0]   ZS       = Z_SEQ[ZSEL];

    state_t               state_q, state_d;
    logic [M-1:0][N-1:0]  win_q, win_d;
    logic [CB-1:0]        idx_q, idx_d;
    logic [5:0]           zcnt_q, zcnt_d;
    logic [N-1:0]         new_word;

    simon_key_round #(
        .N (N),
        .M (M)
    ) u_round (
        .window   (win_q),
        .zbit     (ZS[zcnt_q]),
        .new_word (new_word)
    );

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        idx_d     = idx_q;
        zcnt_d    = zcnt_q;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    win_d   = key_in;
                    idx_d   = '0;
                    zcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        for (int j = 0; j < M - 1; j++) begin
                            win_d[j] = win_q[j+1];
                        end
                        win_d[M-1] = new_word;
                        idx_d      = idx_q + CB'(1);
                        // z index tracks i mod 62 for the word being generated
                        zcnt_d     = (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            idx_q   <= '0;
            zcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            zcnt_q  <= zcnt_d;
        end
    end

    assign rk_out  = win_q[0];
    assign rk_idx  = idx_q;
    assign rk_last = rk_valid && (idx_q == LAST_IDX);

endmodule

// File: doc/simon_key_scheduler.md
Name: simon_key_scheduler

Overview:
Streaming SIMON key schedule generator covering every standard SIMON variant.
- Accepts one full master key (M words of N bits) over a valid/ready handshake.
- Emits the T round keys k[0]..k[T-1] in order, one per accepted beat, on a second valid/ready handshake.
- Sits between the key register and the round datapath; replaces per-round combinational key expansion with a registered M-word window.

Parameters:
- N, 16, word size in bits (16, 24, 32, 48, 64).
- M, 4, key words (2, 3, 4).
- T, 32, number of round keys.
- ZSEL, 0, z-sequence select (0..4).
- CB, $clog2(T), round index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  master key present.
- key_ready  out  1  block can accept a key.
- key_in  in  M*N  master key; bits [j*N +: N] hold k[j].
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer accepts round key.
- rk_out  out  N  current round key.
- rk_idx  out  CB  index i of rk_out.
- rk_last  out  1  high when rk_idx == T-1 and rk_valid.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, key_ready=1, rk_valid=0, rk_out=0, rk_idx=0, rk_last=0, window cleared, z counter=0. Reset mid-stream aborts immediately; no further round keys are emitted until a new key is loaded.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&&key_ready: window[j] <= k[j] for j=0..M-1; rk_idx <= 0; zcnt <= 0; next state RUN.
  - Key load latency is 1 cycle: rk_valid=1 on the cycle after the key handshake.
- RUN:
  - key_ready=0; key_valid is ignored.
  - rk_valid=1; rk_out=window[0]; rk_last=(rk_idx==T-1).
  - On rk_ready with rk_idx<T-1: window shifts down (window[j] <= window[j+1]); window[M-1] <= new; rk_idx++; zcnt <= (zcnt==61)?0:zcnt+1.
  - On rk_ready with rk_idx==T-1: return to IDLE, rk_valid=0 next cycle. A key may not be accepted in that same cycle; key_ready rises the next cycle.
  - rk_ready low: all state held, outputs stable (AXI-style: rk_out must not change while rk_valid&&!rk_ready).
  - Throughput: one round key per cycle under continuous rk_ready.
- New word computation (combinational from the window, registered on shift):
  - tmp = ror(window[M-1], 3).
  - If M==4: tmp ^= window[1].
  - tmp ^= ror(tmp, 1).
  - new = ~window[0] ^ tmp ^ {{(N-1){0}}, z[ZSEL][zcnt]} ^ N'd3.
  - All arithmetic is N-bit modular; ror is rotate right within N bits.
- The z index equals i mod 62 for generated word k[i+M] while window[0]=k[i]. The mod-62 counter wraps 61->0, which is exercised for T>62.
- Keys k[0..M-1] are emitted unmodified.
- Illegal (N,M,T,ZSEL) combinations are an elaboration error via $fatal. Legal tuples:
  - (16,4,32,0), (24,3,36,0), (24,4,36,1)
  - (32,3,42,2), (32,4,44,3)
  - (48,2,52,2), (48,3,54,3)
  - (64,2,68,2), (64,3,69,3), (64,4,72,4)

Decomposition:
- Package simon_pkg:
  - Z_SEQ[5] as 62-bit constants, bit j = element j of the standard sequence (z0 element 0 = 1, so z0 = 62'b0110011100001101010010001011111_0110011100001101010010001011111 with bit 0 at the right).
  - state_t enum {IDLE, RUN}.
  - function simon_cfg_legal(N,M,T,ZSEL).
- One sub-module, simon_key_round: combinational new-word logic with ports window[M], zbit -> new. It is unit-testable against a reference model.

Test Plan:
- SIMON32/64, key words k3..k0 = 1918 1110 0908 0100, rk_ready tied 1 -> rk_out sequence starts 0100, 0908, 1110, 1918, 71c3, b649; 32 beats; rk_last only on rk_idx=31; key_ready returns 1 cycle after.
- Same key with rk_ready toggled randomly (about 50%) -> identical sequence; rk_out and rk_idx stable whenever rk_valid&&!rk_ready.
- SIMON128/128 (N=64, M=2, T=68, ZSEL=2), all-zero-except-bit key -> full 68 keys match the golden model; check rounds 62-67 use zcnt wrapped to 0..5.
- Assert rst at rk_idx=10 -> outputs reach reset values asynchronously; a new key load restarts at rk_idx=0 with the correct sequence.
- key_valid held high through RUN -> no reload; second key accepted only after rk_last handshake; back-to-back keys produce two full, correct streams.
- Elaborate N=32, M=4, T=42 -> $fatal at elaboration.
